// File: rtl/ratio_pool.sv
// Two-channel sum buffer with a per-point restoring divider producing saturated
// fixed-point ratios (stokes << FRAC_BITS) / antistokes, streamed and stored.
module ratio_pool #(
  parameter  int POINTS    = 8,
  parameter  int SUM_W     = 29,
  parameter  int FRAC_BITS = 7,
  parameter  int Q_W       = 12,
  localparam int DIV_W     = SUM_W + FRAC_BITS,
  localparam int IDX_W     = (POINTS > 1) ? $clog2(POINTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [POINTS*SUM_W-1:0] sum_in,
  input  logic                    sum_valid,
  input  logic                    sum_ch,
  input  logic                    flush,
  output logic                    busy,
  output logic [Q_W-1:0]          q_data,
  output logic [IDX_W-1:0]        q_index,
  output logic                    q_valid,
  output logic                    q_sat,
  output logic [POINTS*Q_W-1:0]   store,
  output logic                    done,
  output logic                    overrun
);

  localparam int ITER_W = $clog2(DIV_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DIV   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [POINTS*SUM_W-1:0] stokes_q, stokes_d, anti_q, anti_d;
  logic                    have_s_q, have_s_d, have_a_q, have_a_d;
  logic [POINTS*Q_W-1:0]   store_q, store_d;
  logic [Q_W-1:0]          q_data_q, q_data_d;
  logic [IDX_W-1:0]        q_index_q, q_index_d, idx_q, idx_d;
  logic                    q_valid_q, q_valid_d, q_sat_q, q_sat_d;
  logic                    done_q, done_d, overrun_q, overrun_d;
  logic [ITER_W-1:0]       iter_q, iter_d;
  logic [SUM_W:0]          rem_q, rem_d;
  logic [DIV_W-1:0]        dvd_q, dvd_d;
  logic [SUM_W-1:0]        dvs_q, dvs_d;

  logic [SUM_W+1:0]        rem_shift, rem_diff;
  logic                    quo_bit, sat;
  logic [Q_W-1:0]          result;

  // Input handshake: sum_valid is a one-cycle strobe with no ready; it is only
  // accepted in IDLE, and a strobe arriving in any other state is reported by overrun.
  always_comb begin
    state_d   = state_q;
    stokes_d  = stokes_q;
    anti_d    = anti_q;
    have_s_d  = have_s_q;
    have_a_d  = have_a_q;
    store_d   = store_q;
    q_data_d  = q_data_q;
    q_index_d = q_index_q;
    q_valid_d = 1'b0;
    q_sat_d   = q_sat_q;
    done_d    = 1'b0;
    overrun_d = sum_valid && (state_q != S_IDLE);
    idx_d     = idx_q;
    iter_d    = iter_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;

    // Top bit of the difference is the borrow: clear means rem_shift >= divisor.
    rem_shift = {rem_q, dvd_q[DIV_W-1]};
    rem_diff  = rem_shift - {2'b00, dvs_q};
    quo_bit   = ~rem_diff[SUM_W+1];
    sat       = (dvs_q == '0) || ((dvd_q >> Q_W) != '0);
    result    = sat ? '1 : dvd_q[Q_W-1:0];

    if (flush) begin
      state_d  = S_IDLE;
      have_s_d = 1'b0;
      have_a_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sum_valid) begin
            if (sum_ch) begin
              anti_d   = sum_in;
              have_a_d = 1'b1;
            end else begin
              stokes_d = sum_in;
              have_s_d = 1'b1;
            end
          end
          if (have_s_q && have_a_q) begin
            state_d = S_LOAD;
            store_d = '0;
            idx_d   = '0;
          end
        end
        S_LOAD: begin
          rem_d   = '0;
          dvd_d   = {stokes_q[SUM_W*idx_q +: SUM_W], {FRAC_BITS{1'b0}}};
          dvs_d   = anti_q[SUM_W*idx_q +: SUM_W];
          iter_d  = '0;
          state_d = S_DIV;
        end
        S_DIV: begin
          rem_d  = quo_bit ? rem_diff[SUM_W:0] : rem_shift[SUM_W:0];
          dvd_d  = {dvd_q[DIV_W-2:0], quo_bit};
          iter_d = iter_q + ITER_W'(1);
          if (iter_q == ITER_W'(DIV_W - 1)) state_d = S_WRITE;
        end
        S_WRITE: begin
          store_d[Q_W*idx_q +: Q_W] = result;
          q_data_d  = result;
          q_index_d = idx_q;
          q_sat_d   = sat;
          q_valid_d = 1'b1;
          if (idx_q == IDX_W'(POINTS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
        end
        S_DONE: begin
          done_d   = 1'b1;
          have_s_d = 1'b0;
          have_a_d = 1'b0;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      stokes_q  <= '0;
      anti_q    <= '0;
      have_s_q  <= 1'b0;
      have_a_q  <= 1'b0;
      store_q   <= '0;
      q_data_q  <= '0;
      q_index_q <= '0;
      q_valid_q <= 1'b0;
      q_sat_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= '0;
      iter_q    <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
    end else begin
      state_q   <= state_d;
      stokes_q  <= stokes_d;
      anti_q    <= anti_d;
      have_s_q  <= have_s_d;
      have_a_q  <= have_a_d;
      store_q   <= store_d;
      q_data_q  <= q_data_d;
      q_index_q <= q_index_d;
      q_valid_q <= q_valid_d;
      q_sat_q   <= q_sat_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      idx_q     <= idx_d;
      iter_q    <= iter_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign q_data  = q_data_q;
  assign q_index = q_index_q;
  assign q_valid = q_valid_q;
  assign q_sat   = q_sat_q;
  assign store   = store_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_ratio_pool.sv
// Directed bench for ratio_pool at default parameters: ratios, saturation,
// timing, overrun, flush and mid-batch reset.
module tb_ratio_pool;
  localparam int POINTS = 8;
  localparam int SUM_W  = 29;
  localparam int Q_W    = 12;
  localparam int IDX_W  = 3;

  logic                    clk, rst_n;
  logic [POINTS*SUM_W-1:0] sum_in;
  logic                    sum_valid, sum_ch, flush;
  logic                    busy, q_valid, q_sat, done, overrun;
  logic [Q_W-1:0]          q_data;
  logic [IDX_W-1:0]        q_index;
  logic [POINTS*Q_W-1:0]   store;

  ratio_pool dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ch(sum_ch), .flush(flush), .busy(busy), .q_data(q_data),
    .q_index(q_index), .q_valid(q_valid), .q_sat(q_sat), .store(store),
    .done(done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run, tests_failed;

  logic [SUM_W-1:0] sv[POINTS];
  logic [SUM_W-1:0] av[POINTS];
  logic [Q_W-1:0]   exp_d[POINTS];
  logic             exp_s[POINTS];
  logic [Q_W-1:0]   got_d[POINTS];
  logic             got_s[POINTS];
  int               got_cnt, order_err, extra;
  logic             timeout, busy_at_done;

  // Called at 1 time unit after a rising edge; returns 1 unit after the capture edge.
  task automatic send(input logic ch);
    for (int k = 0; k < POINTS; k++) sum_in[SUM_W*k +: SUM_W] = ch ? av[k] : sv[k];
    sum_ch    = ch;
    sum_valid = 1'b1;
    @(posedge clk); #1;
    sum_valid = 1'b0;
  endtask

  task automatic fill(input int s, input int a);
    for (int k = 0; k < POINTS; k++) begin
      sv[k] = SUM_W'(s);
      av[k] = SUM_W'(a);
    end
  endtask

  // Gathers q_valid results until done, then watches for activity that must not follow.
  task automatic collect();
    got_cnt = 0; order_err = 0; extra = 0; timeout = 1'b1; busy_at_done = 1'b1;
    for (int k = 0; k < POINTS; k++) begin got_d[k] = '0; got_s[k] = 1'b0; end
    for (int c = 0; c < 700; c++) begin
      @(posedge clk); #1;
      if (q_valid) begin
        if (int'(q_index) != got_cnt) order_err++;
        got_d[q_index] = q_data;
        got_s[q_index] = q_sat;
        got_cnt++;
      end
      if (done) begin
        timeout = 1'b0;
        busy_at_done = busy;
        break;
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (q_valid || done || busy) extra++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, q_valid, q_sat, done, overrun} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got busy/qv/sat/done/ovr=%b required 00000", {busy, q_valid, q_sat, done, overrun});
    end
    tests_run++;
    if (q_data !== '0 || q_index !== '0) begin
      tests_failed++;
      $display("FAIL reset_qdata got q_data=%0d q_index=%0d required 0 0", q_data, q_index);
    end
    tests_run++;
    if (store !== '0) begin
      tests_failed++;
      $display("FAIL reset_store got %h required 0", store);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, q_valid, done, overrun} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_idle got busy/qv/done/ovr=%b required 0000", {busy, q_valid, done, overrun});
    end
  endtask

  task automatic test_basic();
    for (int o = 0; o < 2; o++) begin
      fill(100, 50);
      for (int k = 0; k < POINTS; k++) begin exp_d[k] = 12'd256; exp_s[k] = 1'b0; end
      if (o == 0) begin send(1'b0); send(1'b1); end
      else begin send(1'b1); send(1'b0); end
      collect();
      tests_run++;
      if (timeout || got_cnt != POINTS || order_err != 0 || extra != 0 || busy_at_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_seq order=%0d got cnt=%0d ord_err=%0d extra=%0d timeout=%0b busy=%0b required 8 0 0 0 0",
                 o, got_cnt, order_err, extra, timeout, busy_at_done);
      end
      for (int k = 0; k < POINTS; k++) begin
        tests_run++;
        if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k]) begin
          tests_failed++;
          $display("FAIL basic_pt order=%0d pt=%0d got %0d/%0b required %0d/%0b", o, k, got_d[k], got_s[k], exp_d[k], exp_s[k]);
        end
        tests_run++;
        if (store[Q_W*k +: Q_W] !== exp_d[k]) begin
          tests_failed++;
          $display("FAIL basic_store order=%0d slot=%0d got %0d required %0d", o, k, store[Q_W*k +: Q_W], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_sat();
    // 10/3 truncates; divisor 0 and 1000/1 saturate; 31/1 and 4095/128 sit just inside range.
    sv[0] = 10;   av[0] = 3;   exp_d[0] = 12'd426;  exp_s[0] = 1'b0;
    sv[1] = 100;  av[1] = 50;  exp_d[1] = 12'd256;  exp_s[1] = 1'b0;
    sv[2] = 100;  av[2] = 50;  exp_d[2] = 12'd256;  exp_s[2] = 1'b0;
    sv[3] = 5;    av[3] = 0;   exp_d[3] = 12'd4095; exp_s[3] = 1'b1;
    sv[4] = 1000; av[4] = 1;   exp_d[4] = 12'd4095; exp_s[4] = 1'b1;
    sv[5] = 31;   av[5] = 1;   exp_d[5] = 12'd3968; exp_s[5] = 1'b0;
    sv[6] = 0;    av[6] = 50;  exp_d[6] = 12'd0;    exp_s[6] = 1'b0;
    sv[7] = 4095; av[7] = 128; exp_d[7] = 12'd4095; exp_s[7] = 1'b0;
    send(1'b0);
    send(1'b1);
    collect();
    tests_run++;
    if (timeout || got_cnt != POINTS || order_err != 0 || extra != 0) begin
      tests_failed++;
      $display("FAIL sat_seq got cnt=%0d ord_err=%0d extra=%0d timeout=%0b required 8 0 0 0", got_cnt, order_err, extra, timeout);
    end
    for (int k = 0; k < POINTS; k++) begin
      tests_run++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k]) begin
        tests_failed++;
        $display("FAIL sat_pt pt=%0d got %0d/%0b required %0d/%0b", k, got_d[k], got_s[k], exp_d[k], exp_s[k]);
      end
      tests_run++;
      if (store[Q_W*k +: Q_W] !== exp_d[k]) begin
        tests_failed++;
        $display("FAIL sat_store slot=%0d got %0d required %0d", k, store[Q_W*k +: Q_W], exp_d[k]);
      end
    end
  endtask

  task automatic test_timing();
    int load_c, first_c, done_c, nv;
    logic [Q_W-1:0] first_d;
    logic [IDX_W-1:0] first_i;
    load_c = -1; first_c = -1; done_c = -1; nv = 0; first_d = '0; first_i = '1;
    fill(7, 64);
    send(1'b0);
    fill(64, 64);
    send(1'b0);
    send(1'b1);
    for (int c = 1; c < 500; c++) begin
      @(posedge clk); #1;
      if (busy && load_c < 0) load_c = c;
      if (q_valid) begin
        nv++;
        if (first_c < 0) begin first_c = c; first_d = q_data; first_i = q_index; end
      end
      if (done) begin done_c = c; break; end
    end
    tests_run++;
    if (load_c != 1) begin
      tests_failed++;
      $display("FAIL timing_load got %0d cycles required 1", load_c);
    end
    tests_run++;
    if (first_c - load_c != 38) begin
      tests_failed++;
      $display("FAIL timing_first_q got %0d cycles required 38", first_c - load_c);
    end
    tests_run++;
    if (done_c - load_c != 305 || done_c < 0) begin
      tests_failed++;
      $display("FAIL timing_done got %0d cycles required 305", done_c - load_c);
    end
    tests_run++;
    if (first_d !== 12'd128 || first_i !== 3'd0 || nv != POINTS) begin
      tests_failed++;
      $display("FAIL timing_recapture got q=%0d idx=%0d n=%0d required 128 0 8", first_d, first_i, nv);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_overrun();
    fill(100, 50);
    for (int k = 0; k < POINTS; k++) begin exp_d[k] = 12'd256; exp_s[k] = 1'b0; end
    send(1'b0);
    send(1'b1);
    repeat (10) @(posedge clk);
    #1;
    fill(1, 1);
    send(1'b0);
    tests_run++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_pulse got ovr=%0b busy=%0b required 1 1", overrun, busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clear got %0b required 0", overrun);
    end
    collect();
    tests_run++;
    if (timeout || got_cnt != POINTS || order_err != 0 || extra != 0) begin
      tests_failed++;
      $display("FAIL overrun_seq got cnt=%0d ord_err=%0d extra=%0d timeout=%0b required 8 0 0 0", got_cnt, order_err, extra, timeout);
    end
    for (int k = 0; k < POINTS; k++) begin
      tests_run++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k]) begin
        tests_failed++;
        $display("FAIL overrun_pt pt=%0d got %0d/%0b required %0d/%0b", k, got_d[k], got_s[k], exp_d[k], exp_s[k]);
      end
    end
  endtask

  task automatic test_flush();
    int nv, nd;
    for (int k = 0; k < POINTS; k++) begin
      sv[k] = SUM_W'(100 * (k + 1));
      av[k] = SUM_W'(100);
      exp_d[k] = (k < 4) ? Q_W'(128 * (k + 1)) : '0;
    end
    send(1'b0);
    send(1'b1);
    nv = 0;
    for (int c = 0; c < 400 && nv < 4; c++) begin
      @(posedge clk); #1;
      if (q_valid) nv++;
    end
    tests_run++;
    if (nv != 4) begin
      tests_failed++;
      $display("FAIL flush_pre got %0d results required 4", nv);
    end
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_busy got %0b required 0", busy);
    end
    nv = 0; nd = 0;
    for (int c = 0; c < 350; c++) begin
      @(posedge clk); #1;
      if (q_valid) nv++;
      if (done) nd++;
    end
    tests_run++;
    if (nv != 0 || nd != 0) begin
      tests_failed++;
      $display("FAIL flush_quiet got q_valid=%0d done=%0d required 0 0", nv, nd);
    end
    for (int k = 0; k < POINTS; k++) begin
      tests_run++;
      if (store[Q_W*k +: Q_W] !== exp_d[k]) begin
        tests_failed++;
        $display("FAIL flush_store slot=%0d got %0d required %0d", k, store[Q_W*k +: Q_W], exp_d[k]);
      end
    end
    // Flush dropped both flags, so a lone antistokes capture must not start a batch.
    send(1'b1);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_flags got busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    fill(100, 50);
    send(1'b0);
    send(1'b1);
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({busy, q_valid, q_sat, done, overrun} !== 5'b0 || q_data !== '0 || q_index !== '0 || store !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs got busy=%0b q=%0d idx=%0d store=%h required all 0", busy, q_data, q_index, store);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || store !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_idle got busy=%0b store=%h required 0 0", busy, store);
    end
    fill(200, 50);
    for (int k = 0; k < POINTS; k++) begin exp_d[k] = 12'd512; exp_s[k] = 1'b0; end
    send(1'b1);
    send(1'b0);
    collect();
    tests_run++;
    if (timeout || got_cnt != POINTS || order_err != 0 || extra != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_seq got cnt=%0d ord_err=%0d extra=%0d timeout=%0b required 8 0 0 0", got_cnt, order_err, extra, timeout);
    end
    for (int k = 0; k < POINTS; k++) begin
      tests_run++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k] || store[Q_W*k +: Q_W] !== exp_d[k]) begin
        tests_failed++;
        $display("FAIL rst_mid_pt pt=%0d got %0d/%0b store=%0d required %0d/%0b", k, got_d[k], got_s[k], store[Q_W*k +: Q_W], exp_d[k], exp_s[k]);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    sum_in = '0;
    sum_valid = 1'b0;
    sum_ch = 1'b0;
    flush = 1'b0;
    test_reset();
    test_basic();
    test_sat();
    test_timing();
    test_overrun();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
